dmem_responder: RTL and testbench

- Data-memory responder for the pipeline's memory stage. It accepts the load/store request presented in M (address = aluoutM, store data = writedataM) and returns load data on readdataM.
- It inserts a configurable number of wait states and drives a stall request to the hazard unit while the access is in flight.
- It handles byte/halfword/word sizes, load sign-extension and alignment checking. Backing store is an on-chip word array.

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-stage data responder: word-array backing store with configurable wait states,
// byte/half/word lanes, load extension and alignment checking.
module dmem_responder #(
  parameter int unsigned AW      = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          misaligned_c, accept_c, access_c;

  logic          l_we, l_sign;
  logic [1:0]    l_size, l_off;
  logic [AW-1:0] l_idx;
  logic [31:0]   l_wdata;

  logic [31:0]   mem [DEPTH];
  logic [3:0]    be_c;
  logic [31:0]   wlane_c, rword_c, rext_c;
  logic [15:0]   rshift_c;
  logic          unused_addr_c;

  assign unused_addr_c = ^req_addr[31:AW+2];

  always_comb begin
    misaligned_c = 1'b0;
    case (req_size)
      2'b01:   misaligned_c = req_addr[0];
      2'b10:   misaligned_c = |req_addr[1:0];
      2'b11:   misaligned_c = 1'b1;
      default: misaligned_c = 1'b0;
    endcase
  end

  // Next-state, stall and error decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    addr_err  = 1'b0;
    accept_c  = 1'b0;
    access_c  = 1'b0;
    case (state)
      IDLE: begin
        if (req_en) begin
          if (misaligned_c) begin
            addr_err = 1'b1;
          end else begin
            stall     = 1'b1;
            accept_c  = 1'b1;
            cnt_nxt   = CW'(LATENCY - 1);
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          access_c  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= (state_nxt == DONE);
    end
  end

  // Request captured at acceptance; the datapath may change req_* afterwards
  always_ff @(posedge clk) begin
    if (accept_c) begin
      l_we    <= req_we;
      l_sign  <= req_sign;
      l_size  <= req_size;
      l_off   <= req_addr[1:0];
      l_idx   <= req_addr[AW+1:2];
      l_wdata <= req_wdata;
    end
  end

  always_comb begin
    be_c    = 4'b1111;
    wlane_c = l_wdata;
    case (l_size)
      2'b00: begin
        be_c    = 4'b0001 << l_off;
        wlane_c = {4{l_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = l_off[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{l_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Reset on the completing edge suppresses the write
  always_ff @(posedge clk) begin
    if (!rst && access_c && l_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[l_idx][8*i +: 8] <= wlane_c[8*i +: 8];
      end
    end
  end

  assign rword_c  = mem[l_idx];
  assign rshift_c = 16'(rword_c >> {l_off, 3'b000});

  always_comb begin
    case (l_size)
      2'b00:   rext_c = l_sign ? {{24{rshift_c[7]}}, rshift_c[7:0]} : {24'b0, rshift_c[7:0]};
      2'b01:   rext_c = l_sign ? {{16{rshift_c[15]}}, rshift_c} : {16'b0, rshift_c};
      default: rext_c = rword_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (access_c && !l_we) begin
      rdata <= rext_c;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed load/store vectors checked against a byte-addressed
// transaction model plus literal expectations.
module tb_dmem_responder;
  localparam int unsigned AW = 10;
  localparam int unsigned L  = 2;
  localparam int unsigned MB = 1 << (AW + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_en = 1'b0, req_we = 1'b0, req_sign = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rdata;
  logic        stall, done, addr_err;

  int checks = 0;
  int failures = 0;

  dmem_responder #(.AW(AW), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_we(req_we), .req_size(req_size),
    .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .rdata(rdata), .stall(stall), .done(done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit misal(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
  endfunction

  // Transaction model: byte memory, accepted request occupies cycles t0..t0+L+1
  logic [7:0]  mm [MB];
  bit          pend = 0, armed = 0;
  int          t0 = 0, free_at = 0, cyc = 0;
  logic        p_we, p_sign;
  logic [1:0]  p_size;
  logic [31:0] p_addr, p_wdata, exp_rd;

  initial for (int i = 0; i < int'(MB); i++) mm[i] = 8'h00;

  always @(negedge clk) begin
    logic es, ed, ee;
    int a;
    es = 0; ed = 0; ee = 0;
    if (armed && !rst && !pend && cyc >= free_at && req_en) begin
      if (misal(req_size, req_addr)) ee = 1;
      else begin
        pend = 1; t0 = cyc;
        p_we = req_we; p_sign = req_sign; p_size = req_size;
        p_addr = req_addr; p_wdata = req_wdata;
      end
    end
    if (pend) begin
      es = (cyc <= t0 + int'(L));
      ed = (cyc == t0 + int'(L) + 1);
    end
    if (armed) begin
      chk("stall", 32'(stall), 32'(es));
      chk("done", 32'(done), 32'(ed));
      chk("addr_err", 32'(addr_err), 32'(ee));
      chk("rdata", rdata, exp_rd);
    end
    if (rst) begin
      pend = 0; exp_rd = '0; free_at = cyc + 1; armed = 1;
    end else if (pend && cyc == t0 + int'(L)) begin
      a = int'(p_addr % MB);
      if (p_we) begin
        mm[a] = p_wdata[7:0];
        if (p_size != 2'b00) mm[a+1] = p_wdata[15:8];
        if (p_size == 2'b10) begin mm[a+2] = p_wdata[23:16]; mm[a+3] = p_wdata[31:24]; end
      end else if (p_size == 2'b00) begin
        exp_rd = p_sign ? {{24{mm[a][7]}}, mm[a]} : {24'h0, mm[a]};
      end else if (p_size == 2'b01) begin
        exp_rd = p_sign ? {{16{mm[a+1][7]}}, mm[a+1], mm[a]} : {16'h0, mm[a+1], mm[a]};
      end else begin
        exp_rd = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
      end
    end else if (pend && cyc == t0 + int'(L) + 1) begin
      pend = 0; free_at = cyc + 1;
    end
    cyc++;
  end

  // Present one request from posedge+1 until done or addr_err is seen
  task automatic op(input logic we, input logic [1:0] size, input logic sign,
                    input logic [31:0] addr, input logic [31:0] wd,
                    output logic [31:0] rd, output int ns, output bit err);
    bit got;
    req_en = 1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wd;
    ns = 0; err = 0; got = 0; rd = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (stall) ns++;
      if (addr_err) begin err = 1; got = 1; end
      else if (done) begin rd = rdata; got = 1; end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL op_timeout addr=%h actual=none required=done", addr);
    end
    @(posedge clk); #1;
    req_en = 0;
  endtask

  logic [31:0] rd;
  int ns;
  bit err;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    @(posedge clk); #1;

    op(1, 2'b10, 0, 32'h04, 32'h0, rd, ns, err);
    op(1, 2'b10, 0, 32'h20, 32'h0, rd, ns, err);

    op(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, ns, err);
    chk("sw_stall_cycles", 32'(ns), 32'd3);
    op(0, 2'b10, 0, 32'h10, 32'h0, rd, ns, err);
    chk("lw_stall_cycles", 32'(ns), 32'd3);
    chk("lw_10", rd, 32'hDEADBEEF);

    op(1, 2'b00, 0, 32'h05, 32'h1AB, rd, ns, err);
    op(0, 2'b10, 0, 32'h04, 32'h0, rd, ns, err);
    chk("sb_lane1", rd, 32'h0000AB00);

    op(1, 2'b10, 0, 32'h08, 32'h80FF7F01, rd, ns, err);
    op(0, 2'b00, 1, 32'h0B, 32'h0, rd, ns, err);
    chk("lb_B", rd, 32'hFFFFFF80);
    op(0, 2'b00, 0, 32'h0B, 32'h0, rd, ns, err);
    chk("lbu_B", rd, 32'h00000080);
    op(0, 2'b01, 1, 32'h0A, 32'h0, rd, ns, err);
    chk("lh_A", rd, 32'hFFFF80FF);
    op(0, 2'b01, 0, 32'h08, 32'h0, rd, ns, err);
    chk("lhu_8", rd, 32'h00007F01);

    op(0, 2'b01, 1, 32'h03, 32'h0, rd, ns, err);
    chk("mis_lh_err", 32'(err), 32'd1);
    chk("mis_lh_stall", 32'(ns), 32'd0);
    chk("mis_lh_rdata", rdata, 32'h00007F01);
    op(1, 2'b10, 0, 32'h06, 32'hFFFFFFFF, rd, ns, err);
    chk("mis_sw_err", 32'(err), 32'd1);
    op(0, 2'b10, 0, 32'h04, 32'h0, rd, ns, err);
    chk("mis_sw_nowrite", rd, 32'h0000AB00);
    op(0, 2'b11, 0, 32'h00, 32'h0, rd, ns, err);
    chk("size11_err", 32'(err), 32'd1);

    req_en = 1; req_we = 1; req_size = 2'b10; req_sign = 0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); @(posedge clk); #1;
    rst = 1; req_en = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_busy_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    op(0, 2'b10, 0, 32'h10, 32'h0, rd, ns, err);
    chk("lw_10_after_rst", rd, 32'hDEADBEEF);
    op(0, 2'b10, 0, 32'h20, 32'h0, rd, ns, err);
    chk("rst_store_dropped", rd, 32'h0);

    op(1, 2'b10, 0, 32'h1000, 32'hCAFEF00D, rd, ns, err);
    op(0, 2'b10, 0, 32'h0, 32'h0, rd, ns, err);
    chk("wrap_lw", rd, 32'hCAFEF00D);

    for (int i = 0; i < 4; i++) begin
      op(1, 2'b10, 0, 32'h1000 + 32'(4*i), 32'hA5000000 + 32'(i), rd, ns, err);
      chk("alt_sw_stall", 32'(ns), 32'd3);
      op(0, 2'b10, 0, 32'(4*i), 32'h0, rd, ns, err);
      chk("alt_lw_stall", 32'(ns), 32'd3);
      chk("alt_lw_data", rd, 32'hA5000000 + 32'(i));
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
